// File: rtl/bip_fetch_unit.sv
// bip_fetch_unit: BIP I instruction fetch and sequencing stage (FETCH -> WAIT -> EXEC, stops on HLT)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       run enable, only looked at in FETCH
//   prog_addr    program memory address (always the current pc)
//   prog_rd      program memory read strobe
//   prog_data    program memory read data, valid the cycle after prog_rd
//   Opcode       IR[15:11] to the decoder during EXEC, 0 otherwise
//   Operand      IR[10:0] to the datapath during EXEC, 0 otherwise
//   instr_valid  high for the single EXEC cycle of each instruction
//   illegal      high in EXEC when the opcode exceeds LAST_OPCODE
//   halted       high once an HLT (opcode 0) has been fetched
//   pc           program counter
//   instr_count  retired instruction count (HLT is not counted)
module bip_fetch_unit #(
    parameter int PC_WIDTH     = 11,
    parameter int INSTR_WIDTH  = 16,
    parameter int OPCODE_WIDTH = 5,
    parameter int LAST_OPCODE  = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    output logic [PC_WIDTH-1:0]                 prog_addr,
    output logic                                prog_rd,
    input  logic [INSTR_WIDTH-1:0]              prog_data,
    output logic [OPCODE_WIDTH-1:0]             Opcode,
    output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] Operand,
    output logic                                instr_valid,
    output logic                                illegal,
    output logic                                halted,
    output logic [PC_WIDTH-1:0]                 pc,
    output logic [15:0]                         instr_count
);
    localparam int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

    typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;

    state_t                   state, nextState;
    logic [INSTR_WIDTH-1:0]   ir;
    logic [OPCODE_WIDTH-1:0]  irOpcode;
    logic [OPCODE_WIDTH-1:0]  dataOpcode;

    assign irOpcode   = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign dataOpcode = prog_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign prog_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            ir          <= '0;
            pc          <= '0;
            instr_count <= '0;
        end else begin
            state <= nextState;
            if (state == WAIT)
                ir <= prog_data;
            if (state == EXEC) begin
                pc          <= pc + PC_WIDTH'(1);
                instr_count <= instr_count + 16'd1;
            end
        end
    end

    always_comb begin
        nextState   = state;
        prog_rd     = 1'b0;
        Opcode      = '0;
        Operand     = '0;
        instr_valid = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state)
            FETCH: begin
                nextState = enable ? WAIT : FETCH;
                // rst_n gate keeps the strobe low while reset is held, even with enable high
                prog_rd   = enable & rst_n;
            end
            WAIT:
                nextState = (dataOpcode == '0) ? HALT : EXEC;
            EXEC: begin
                nextState   = FETCH;
                Opcode      = irOpcode;
                Operand     = ir[OPERAND_WIDTH-1:0];
                instr_valid = 1'b1;
                illegal     = irOpcode > OPCODE_WIDTH'(LAST_OPCODE);
            end
            default: begin
                nextState = HALT;
                halted    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_bip_fetch_unit.sv
// tb_bip_fetch_unit: scoreboard bench for bip_fetch_unit with a synchronous program ROM model
module tb_bip_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] prog_addr;
    logic        prog_rd;
    logic [15:0] prog_data;
    logic [4:0]  Opcode;
    logic [10:0] Operand;
    logic        instr_valid;
    logic        illegal;
    logic        halted;
    logic [10:0] pc;
    logic [15:0] instr_count;

    int nCompared = 0;
    int nMismatched = 0;

    logic [15:0] rom [2048];

    typedef struct {
        logic [4:0]  op;
        logic [10:0] opnd;
        logic [10:0] addr;
    } exp_t;

    exp_t sbq[$];
    exp_t mon;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (prog_rd) prog_data <= rom[prog_addr];

    bip_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_data(prog_data),
        .Opcode(Opcode), .Operand(Operand), .instr_valid(instr_valid),
        .illegal(illegal), .halted(halted), .pc(pc), .instr_count(instr_count)
    );

    function automatic void pushExp(input logic [10:0] a);
        exp_t e;
        e.op   = rom[a][15:11];
        e.opnd = rom[a][10:0];
        e.addr = a;
        sbq.push_back(e);
    endfunction

    // Every EXEC cycle is matched against the oldest expected instruction
    always @(negedge clk) begin
        if (rst_n && instr_valid) begin
            nCompared++;
            if (sbq.size() == 0) begin
                nMismatched++;
                $display("FAIL exec_unexpected: Opcode=%0d pc=%0h with nothing expected", Opcode, pc);
            end else begin
                mon = sbq.pop_front();
                if ({Opcode, Operand, illegal, pc} !== {mon.op, mon.opnd, (mon.op > 5'd7), mon.addr}) begin
                    nMismatched++;
                    $display("FAIL exec: got op=%0d opnd=%0h ill=%0b pc=%0h, expected op=%0d opnd=%0h ill=%0b pc=%0h",
                             Opcode, Operand, illegal, pc, mon.op, mon.opnd, (mon.op > 5'd7), mon.addr);
                end
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        sbq.delete();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n  = 1'b0;
        enable = 1'b1;
        #1;
        nCompared++;
        if ({prog_rd, instr_valid, illegal, halted, Opcode, Operand, pc, instr_count, prog_addr} !== '0) begin
            nMismatched++;
            $display("FAIL reset_outputs: rd=%0b v=%0b ill=%0b h=%0b op=%0h opnd=%0h pc=%0h cnt=%0h, required all 0",
                     prog_rd, instr_valid, illegal, halted, Opcode, Operand, pc, instr_count);
        end
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic test_single();
        doReset();
        rom[0] = 16'h2005;
        pushExp(11'd0);
        enable = 1'b1;
        #1;
        nCompared++;
        if ({prog_rd, prog_addr} !== {1'b1, 11'd0}) begin
            nMismatched++;
            $display("FAIL single_fetch: rd=%0b addr=%0h, required rd=1 addr=0", prog_rd, prog_addr);
        end
        @(negedge clk); #1;
        nCompared++;
        if ({prog_rd, instr_valid} !== 2'b00) begin
            nMismatched++;
            $display("FAIL single_wait: rd=%0b valid=%0b, required 0 0", prog_rd, instr_valid);
        end
        @(negedge clk); #1;
        nCompared++;
        if (sbq.size() != 0) begin
            nMismatched++;
            $display("FAIL single_latency: %0d instructions pending in cycle 2, required 0", sbq.size());
        end
        @(negedge clk); #1;
        nCompared++;
        if ({pc, instr_count} !== {11'd1, 16'd1}) begin
            nMismatched++;
            $display("FAIL single_retire: pc=%0h cnt=%0h, required pc=1 cnt=1", pc, instr_count);
        end
        enable = 1'b0;
    endtask

    task automatic test_sequence();
        logic ok = 1'b1;
        doReset();
        for (int i = 0; i < 7; i++) begin
            rom[i] = {5'(i + 1), 11'h7FF};
            pushExp(11'(i));
        end
        enable = 1'b1;
        for (int c = 0; c < 21; c++) begin
            #1;
            if (instr_valid !== 1'(c % 3 == 2)) ok = 1'b0;
            @(negedge clk);
        end
        nCompared++;
        if (!ok || sbq.size() != 0) begin
            nMismatched++;
            $display("FAIL seq_cadence: cadence_ok=%0b pending=%0d, required 1 and 0", ok, sbq.size());
        end
        for (int c = 0; c < 10 && !halted; c++) begin
            @(negedge clk); #1;
        end
        nCompared++;
        if ({halted, pc, instr_count} !== {1'b1, 11'd7, 16'd7}) begin
            nMismatched++;
            $display("FAIL seq_halt: halted=%0b pc=%0h cnt=%0h, required 1 7 7", halted, pc, instr_count);
        end
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if ({Opcode, Operand, instr_valid, prog_rd, halted, pc} !== {5'd0, 11'd0, 2'b00, 1'b1, 11'd7}) ok = 1'b0;
        end
        nCompared++;
        if (!ok) begin
            nMismatched++;
            $display("FAIL seq_halt_hold: op=%0h v=%0b rd=%0b h=%0b pc=%0h, required 0 0 0 1 7",
                     Opcode, instr_valid, prog_rd, halted, pc);
        end
        enable = 1'b0;
    endtask

    task automatic test_stall();
        logic ok = 1'b1;
        doReset();
        rom[0] = 16'h3001;
        rom[1] = 16'h4002;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ({prog_rd, instr_valid, pc} !== {2'b00, 11'd0}) ok = 1'b0;
            @(negedge clk);
        end
        nCompared++;
        if (!ok) begin
            nMismatched++;
            $display("FAIL stall_fetch: rd=%0b v=%0b pc=%0h, required 0 0 0", prog_rd, instr_valid, pc);
        end
        pushExp(11'd0);
        pushExp(11'd1);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if ({prog_rd, instr_valid, pc} !== {2'b00, 11'd1} || sbq.size() != 1) ok = 1'b0;
            @(negedge clk);
        end
        nCompared++;
        if (!ok) begin
            nMismatched++;
            $display("FAIL stall_after_wait: rd=%0b v=%0b pc=%0h pending=%0d, required 0 0 1 1",
                     prog_rd, instr_valid, pc, sbq.size());
        end
        enable = 1'b1;
        for (int c = 0; c < 10 && sbq.size() != 0; c++) begin
            @(negedge clk); #1;
        end
        nCompared++;
        if (sbq.size() != 0) begin
            nMismatched++;
            $display("FAIL stall_resume: %0d instructions never executed, required 0", sbq.size());
        end
        enable = 1'b0;
    endtask

    task automatic test_illegal();
        doReset();
        rom[0] = 16'hF800;
        pushExp(11'd0);
        enable = 1'b1;
        for (int c = 0; c < 10 && sbq.size() != 0; c++) begin
            @(negedge clk); #1;
        end
        nCompared++;
        if ({sbq.size() == 0, illegal, Opcode} !== {1'b1, 1'b1, 5'd31}) begin
            nMismatched++;
            $display("FAIL illegal_exec: done=%0b ill=%0b op=%0d, required 1 1 31", sbq.size() == 0, illegal, Opcode);
        end
        enable = 1'b0;
        @(negedge clk); #1;
        nCompared++;
        if ({pc, instr_count, illegal} !== {11'd1, 16'd1, 1'b0}) begin
            nMismatched++;
            $display("FAIL illegal_retire: pc=%0h cnt=%0h ill=%0b, required 1 1 0", pc, instr_count, illegal);
        end
    endtask

    task automatic test_wrap();
        doReset();
        for (int i = 0; i < 2048; i++) begin
            rom[i] = {5'd1, 11'(i)};
            pushExp(11'(i));
        end
        enable = 1'b1;
        for (int c = 0; c < 6300 && sbq.size() != 0; c++) begin
            @(negedge clk); #1;
        end
        enable = 1'b0;
        nCompared++;
        if (sbq.size() != 0) begin
            nMismatched++;
            $display("FAIL wrap_run: %0d instructions never executed, required 0", sbq.size());
        end
        @(negedge clk); #1;
        nCompared++;
        if ({pc, prog_addr, instr_count} !== {11'd0, 11'd0, 16'd2048}) begin
            nMismatched++;
            $display("FAIL wrap_pc: pc=%0h addr=%0h cnt=%0h, required 0 0 800", pc, prog_addr, instr_count);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        rom[0] = 16'h2005;
        pushExp(11'd0);
        enable = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sbq.delete();
        nCompared++;
        if ({prog_rd, instr_valid, illegal, halted, Opcode, Operand, pc, instr_count, prog_addr} !== '0) begin
            nMismatched++;
            $display("FAIL reset_mid_wait: rd=%0b v=%0b h=%0b op=%0h pc=%0h cnt=%0h, required all 0",
                     prog_rd, instr_valid, halted, Opcode, pc, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pushExp(11'd0);
        #1;
        nCompared++;
        if ({prog_rd, prog_addr} !== {1'b1, 11'd0}) begin
            nMismatched++;
            $display("FAIL restart_fetch: rd=%0b addr=%0h, required rd=1 addr=0", prog_rd, prog_addr);
        end
        for (int c = 0; c < 10 && sbq.size() != 0; c++) begin
            @(negedge clk); #1;
        end
        enable = 1'b0;
        nCompared++;
        if (sbq.size() != 0) begin
            nMismatched++;
            $display("FAIL restart_exec: %0d instructions never executed, required 0", sbq.size());
        end

        doReset();
        enable = 1'b1;
        for (int c = 0; c < 10 && !halted; c++) begin
            @(negedge clk); #1;
        end
        nCompared++;
        if ({halted, pc, instr_count} !== {1'b1, 11'd0, 16'd0}) begin
            nMismatched++;
            $display("FAIL hlt_at_zero: halted=%0b pc=%0h cnt=%0h, required 1 0 0", halted, pc, instr_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++;
        if ({prog_rd, instr_valid, illegal, halted, Opcode, Operand, pc, instr_count} !== '0) begin
            nMismatched++;
            $display("FAIL reset_in_halt: rd=%0b v=%0b h=%0b op=%0h pc=%0h, required all 0",
                     prog_rd, instr_valid, halted, Opcode, pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nCompared++;
        if ({prog_rd, prog_addr, halted} !== {1'b1, 11'd0, 1'b0}) begin
            nMismatched++;
            $display("FAIL restart_after_halt: rd=%0b addr=%0h h=%0b, required 1 0 0", prog_rd, prog_addr, halted);
        end
        enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
        test_reset();
        test_single();
        test_sequence();
        test_stall();
        test_illegal();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
